// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin share of one immediate extender between two requesters; optional IMM_ZERO_EXT_EN adds per-port zero-extend selects
module imm_ext_arbiter #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [IN_W-1:0]  imm0,
`ifdef IMM_ZERO_EXT_EN
  input  logic             zext0,
  input  logic             zext1,
`endif
  output logic             gnt0,
  input  logic             req1,
  input  logic [IN_W-1:0]  imm1,
  output logic             gnt1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_tag
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic prio_q, tag_q, can_accept, pick1, grant, zext_sel;
  logic [OUT_W-1:0] data_q, ext;
  logic [IN_W-1:0] imm_sel;
  assign can_accept = (state_q == EMPTY) || out_ready;
  assign pick1 = req1 && (!req0 || prio_q);
  assign gnt1 = !reset && can_accept && pick1;
  assign gnt0 = !reset && can_accept && req0 && !pick1;
  assign grant = gnt0 || gnt1;
  assign imm_sel = gnt1 ? imm1 : imm0;
`ifdef IMM_ZERO_EXT_EN
  assign zext_sel = gnt1 ? zext1 : zext0;
`else
  assign zext_sel = 1'b0;
`endif
  // extend the selected immediate: replicate the top bit unless zero-extension is requested
  always_comb begin
    ext = '0;
    ext[IN_W-1:0] = imm_sel;
    for (int i = IN_W; i < OUT_W; i++) ext[i] = !zext_sel && imm_sel[IN_W-1];
  end
  // state register plus result/priority capture on each grant
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      prio_q  <= 1'b0;
      tag_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        data_q <= ext;
        tag_q  <= gnt1;
        prio_q <= !gnt1;
      end
    end
  end
  // next state: a grant always fills; otherwise a taken result drains
  always_comb state_d = grant ? FULL : (out_ready ? EMPTY : state_q);
  // outputs straight from the buffer registers
  always_comb begin
    out_valid = state_q == FULL;
    out_data  = data_q;
    out_tag   = tag_q;
  end
endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter: table-driven directed check of arbitration, extension, backpressure and reset
module tb_imm_ext_arbiter;
  logic clk = 0, reset, req0, req1, out_ready, gnt0, gnt1, out_valid, out_tag, zext0, zext1;
  logic [11:0] imm0, imm1;
  logic [15:0] out_data;
  int checks = 0, errors = 0;
  typedef struct {
    logic rst, r0; logic [11:0] i0; logic z0;
    logic r1; logic [11:0] i1; logic z1; logic rdy;
    logic g0, g1, v; logic [15:0] d; logic t;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  imm_ext_arbiter dut (
    .clk(clk), .reset(reset), .req0(req0), .imm0(imm0),
`ifdef IMM_ZERO_EXT_EN
    .zext0(zext0), .zext1(zext1),
`endif
    .gnt0(gnt0), .req1(req1), .imm1(imm1), .gnt1(gnt1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );
  function automatic vec_t mk(logic rst, logic r0, logic [11:0] i0, logic z0, logic r1, logic [11:0] i1,
                              logic z1, logic rdy, logic g0, logic g1, logic v, logic [15:0] d, logic t);
    vec_t x;
    x.rst = rst; x.r0 = r0; x.i0 = i0; x.z0 = z0; x.r1 = r1; x.i1 = i1; x.z1 = z1; x.rdy = rdy;
    x.g0 = g0; x.g1 = g1; x.v = v; x.d = d; x.t = t;
    return x;
  endfunction
  task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d act=%h exp=%h", name, idx, act, exp);
    end
  endtask
  initial begin
    reset = 1; req0 = 0; req1 = 0; imm0 = 0; imm1 = 0; zext0 = 0; zext1 = 0; out_ready = 0;
    //              rst r0 imm0    z0 r1 imm1    z1 rdy g0 g1 v  data      t
    vecs.push_back(mk(1, 1, 12'h555, 0, 1, 12'h2AA, 0, 1, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 12'h123, 0, 0, 12'h000, 0, 1, 1, 0, 1, 16'h0123, 0));
    vecs.push_back(mk(0, 0, 12'h000, 0, 1, 12'hFE1, 0, 1, 0, 1, 1, 16'hFFE1, 1));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 0, 16'hFFE1, 1));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 0, 0, 16'hFFE1, 1));
    vecs.push_back(mk(1, 0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 12'h001, 0, 1, 12'h7FF, 0, 1, 1, 0, 1, 16'h0001, 0));
    vecs.push_back(mk(0, 1, 12'h001, 0, 1, 12'h7FF, 0, 1, 0, 1, 1, 16'h07FF, 1));
    vecs.push_back(mk(0, 1, 12'h001, 0, 1, 12'h7FF, 0, 1, 1, 0, 1, 16'h0001, 0));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 0, 0, 0, 16'h0001, 0));
    vecs.push_back(mk(0, 1, 12'h800, 0, 0, 12'h000, 0, 1, 1, 0, 1, 16'hF800, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 1, 12'h800, 0, 0, 12'h000, 0, 0, 0, 0, 1, 16'hF800, 0));
    vecs.push_back(mk(0, 1, 12'h800, 0, 0, 12'h000, 0, 1, 1, 0, 1, 16'hF800, 0));
    vecs.push_back(mk(0, 1, 12'h7FF, 0, 0, 12'h000, 0, 1, 1, 0, 1, 16'h07FF, 0));
    vecs.push_back(mk(0, 0, 12'h000, 0, 1, 12'h0AB, 0, 0, 0, 0, 1, 16'h07FF, 0));
    vecs.push_back(mk(0, 0, 12'h000, 0, 1, 12'h0AB, 0, 1, 0, 1, 1, 16'h00AB, 1));
    vecs.push_back(mk(0, 1, 12'hFE1, 0, 0, 12'h000, 0, 1, 1, 0, 1, 16'hFFE1, 0));
    vecs.push_back(mk(1, 1, 12'h001, 0, 1, 12'h7FF, 0, 0, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 12'h001, 0, 1, 12'h7FF, 0, 1, 1, 0, 1, 16'h0001, 0));
`ifdef IMM_ZERO_EXT_EN
    vecs.push_back(mk(0, 1, 12'hFE1, 1, 0, 12'h000, 0, 1, 1, 0, 1, 16'h0FE1, 0));
    vecs.push_back(mk(0, 1, 12'hFE1, 0, 0, 12'h000, 0, 1, 1, 0, 1, 16'hFFE1, 0));
    vecs.push_back(mk(0, 0, 12'h000, 0, 1, 12'h800, 1, 1, 0, 1, 1, 16'h0800, 1));
`endif
    @(posedge clk); #1;
    foreach (vecs[n]) begin
      reset = vecs[n].rst; req0 = vecs[n].r0; imm0 = vecs[n].i0; zext0 = vecs[n].z0;
      req1 = vecs[n].r1; imm1 = vecs[n].i1; zext1 = vecs[n].z1; out_ready = vecs[n].rdy;
      #2;
      chk("gnt0", n, 16'(gnt0), 16'(vecs[n].g0));
      chk("gnt1", n, 16'(gnt1), 16'(vecs[n].g1));
      @(posedge clk); #1;
      chk("out_valid", n, 16'(out_valid), 16'(vecs[n].v));
      chk("out_data", n, out_data, vecs[n].d);
      chk("out_tag", n, 16'(out_tag), 16'(vecs[n].t));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_ext_arbiter.md
Name: imm_ext_arbiter

Overview:
Shares the single 12-to-16-bit immediate sign-extension resource between two requesters: port 0 (ALU-immediate path in decode) and port 1 (branch/jump offset path). Round-robin arbitration with valid/grant handshakes on the request side. One-entry registered result buffer with valid/ready handshake on the consumer side. Sits between decode and the execute-stage operand muxes.

Parameters:
IN_W, 12, immediate field width in bits
OUT_W, 16, extended result width in bits; must be >= IN_W

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req0  in  1  requester 0 has an immediate to extend
imm0  in  IN_W  requester 0 immediate; stable while req0 high and gnt0 low
gnt0  out  1  requester 0 accepted this cycle (combinational)
req1  in  1  requester 1 has an immediate to extend
imm1  in  IN_W  requester 1 immediate; stable while req1 high and gnt1 low
gnt1  out  1  requester 1 accepted this cycle (combinational)
out_valid  out  1  out_data/out_tag hold a result
out_ready  in  1  consumer takes the result this cycle
out_data  out  OUT_W  extended immediate
out_tag  out  1  requester id that produced out_data

Behaviour:
- Reset: clk and reset are the only clock/reset; reset is synchronous and active-high. While reset is high at a rising edge: out_valid=0, out_data=0, out_tag=0, prio=0, state=EMPTY. gnt0/gnt1 are forced to 0 while reset is high.
- The result buffer is a two-state FSM:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_accept = (state==EMPTY) || out_ready.
- Grant logic is combinational and zero-latency from req:
  - Only req0 high: gnt0 = can_accept.
  - Only req1 high: gnt1 = can_accept.
  - Both high: the port selected by prio is granted (prio=0 picks port 0, prio=1 picks port 1).
  - At most one gnt is high in any cycle.
- On a grant edge from port k:
  - out_data <= imm_k with bit IN_W-1 replicated into bits OUT_W-1..IN_W.
  - out_tag <= k.
  - state <= FULL.
  - prio <= ~k.
- No grant and out_ready high in FULL: state <= EMPTY. out_data and out_tag keep their last values.
- No grant and out_ready low in FULL: hold. out_data and out_tag must not change while out_valid && !out_ready.
- Latency: request granted in cycle N produces out_valid=1 with its data in cycle N+1.
- Throughput: one result per cycle when out_ready is held high. A simultaneous drain and refill in FULL is legal and stays FULL with the new data.
- prio changes only on a grant. A lone requester never flips priority away from a waiting port it did not win against.
- Starvation bound: with both requesters asserted continuously and out_ready=1, grants strictly alternate.
- A requester may deassert req before it is granted; nothing is captured.
- out_ready while EMPTY is ignored.
- Reset during FULL discards the held result; no grant is issued in the reset cycle.
- imm values are treated as two's complement. Extension is pure replication with no saturation or shift. Only OUT_W >= IN_W is supported.

Optional Feature:
Macro: IMM_ZERO_EXT_EN
- Defined:
  - Adds input ports zext0 and zext1 (1 bit each), sampled together with imm_k on grant.
  - zext_k=1 fills the upper OUT_W-IN_W bits with 0 instead of replicating bit IN_W-1.
  - zext_k=0 sign-extends as above.
  - These ports are used for logical-immediate instructions.
- Not defined: the zext ports do not exist and every result is sign-extended.

Test Plan:
- Reset, then req0=1 with imm0=12'h123 and out_ready=1. Required: gnt0=1 in that cycle; next cycle out_valid=1, out_data=16'h0123, out_tag=0.
- req1=1 with imm1=12'hFE1. Required: next cycle out_data=16'hFFE1 and out_tag=1, with $signed(out_data)==$signed(imm1).
- Immediately after reset, raise req0 (12'h001) and req1 (12'h7FF) together and keep them high, out_ready=1. Required grant order is gnt0, gnt1, gnt0, and outputs are 16'h0001, 16'h07FF, 16'h0001.
- Backpressure:
  - Capture 12'h800, giving out_data=16'hF800.
  - Hold out_ready=0 for 3 cycles with req0 high. Required: out_data stays 16'hF800, out_valid=1, gnt0=0 throughout.
  - Raise out_ready. Required: gnt0=1 in that same cycle.
- Reset mid-operation: in state FULL with out_data=16'hFFE1, assert reset for 1 cycle. Required: out_valid=0, out_data=16'h0000, out_tag=0, and the next tie goes to port 0.
- IMM_ZERO_EXT_EN defined: imm0=12'hFE1 with zext0=1 gives 16'h0FE1; imm0=12'hFE1 with zext0=0 gives 16'hFFE1.
